kb_scan_ctrl: RTL and testbench



---
 rtl/kb_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_kb_scan_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kb_scan_ctrl.sv
// 8x8 key matrix scanner: two-scan debounce per key, press/release events
// queued in a small FIFO read through the data port, interrupt while non-empty.
module kb_scan_ctrl #(
  parameter int SCAN_DIV   = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a0,
  input  logic       n_kb_oe,
  input  logic       kb_cp,
  inout  wire  [7:0] d,
  output logic [7:0] n_row,
  input  logic [7:0] n_col,
  output logic       n_int
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {S_DWELL, S_EMIT} state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_div;
  logic [2:0]    r_row, r_col;
  logic [7:0]    r_nrow, r_samp, r_col_s1, r_col_s2;
  logic [63:0]   r_stab, r_raw;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [3:0]    r_cnt;
  logic          r_ovf, r_nint;
  logic          r_oe_q, r_cp_q, r_rd_hit, r_wr_a0;
  logic [1:0]    r_wr_d;

  logic          w_dwell_end, w_emit_last, w_emit;
  logic [5:0]    w_k;
  logic          w_s, w_cand, w_full, w_empty;
  logic          w_pop, w_push, w_ovf_set, w_cmd, w_flush, w_ovf_clr;
  logic          w_rd_end, w_wr_end;
  logic [7:0]    w_code, w_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_DWELL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dwell_end = 1'b0;
    w_emit_last = 1'b0;
    case (r_state)
      S_DWELL: if (r_div == 16'(SCAN_DIV - 1)) begin
        w_dwell_end = 1'b1;
        w_state_nxt = S_EMIT;
      end
      S_EMIT: if (r_col == 3'd7) begin
        w_emit_last = 1'b1;
        w_state_nxt = S_DWELL;
      end
      default: w_state_nxt = S_DWELL;
    endcase
  end

  // A key is reported only when two consecutive scans agree and differ from the debounced state
  assign w_emit    = (r_state == S_EMIT);
  assign w_k       = {r_row, r_col};
  assign w_s       = r_samp[r_col];
  assign w_cand    = w_emit && (w_s == r_raw[w_k]) && (w_s != r_stab[w_k]);
  assign w_full    = (r_cnt == 4'(FIFO_DEPTH));
  assign w_empty   = (r_cnt == 4'd0);
  assign w_rd_end  = n_kb_oe && !r_oe_q;
  assign w_wr_end  = kb_cp && !r_cp_q;
  assign w_pop     = w_rd_end && r_rd_hit && !w_empty;
  assign w_push    = w_cand && (!w_full || w_pop);
  assign w_ovf_set = w_cand && w_full && !w_pop;
  assign w_cmd     = w_wr_end && r_wr_a0;
  assign w_flush   = w_cmd && r_wr_d[0];
  assign w_ovf_clr = w_cmd && r_wr_d[1];
  assign w_code    = {~w_s, 1'b0, r_row, r_col};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div    <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_nrow   <= 8'hFE;
      r_samp   <= '0;
      r_col_s1 <= 8'hFF;
      r_col_s2 <= 8'hFF;
      r_stab   <= '0;
      r_raw    <= '0;
    end else begin
      r_col_s1 <= n_col;
      r_col_s2 <= r_col_s1;
      if (r_state == S_DWELL) begin
        if (w_dwell_end) begin
          r_samp <= ~r_col_s2;
          r_col  <= 3'd0;
        end else begin
          r_div <= r_div + 16'd1;
        end
      end else begin
        r_raw[w_k] <= w_s;
        if (w_push) r_stab[w_k] <= w_s;
        if (w_emit_last) begin
          r_row  <= r_row + 3'd1;
          r_nrow <= {r_nrow[6:0], r_nrow[7]};
          r_div  <= '0;
        end else begin
          r_col <= r_col + 3'd1;
        end
      end
    end
  end

  // Strobe edge detection; the read remembers whether it saw real data so an
  // event arriving mid-read of an empty port is not silently consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_oe_q   <= 1'b1;
      r_cp_q   <= 1'b1;
      r_rd_hit <= 1'b0;
      r_wr_a0  <= 1'b0;
      r_wr_d   <= '0;
    end else begin
      r_oe_q <= n_kb_oe;
      r_cp_q <= kb_cp;
      if (!n_kb_oe) r_rd_hit <= !a0 && !w_empty;
      if (!kb_cp) begin
        r_wr_a0 <= a0;
        r_wr_d  <= d[1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_nint <= 1'b1;
    end else begin
      if (w_flush) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) r_wp <= r_wp + AW'(1);
        if (w_pop)  r_rp <= r_rp + AW'(1);
        if (w_push && !w_pop)      r_cnt <= r_cnt + 4'd1;
        else if (w_pop && !w_push) r_cnt <= r_cnt - 4'd1;
      end
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      r_nint <= w_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_flush) r_mem[r_wp] <= w_code;
  end

  assign w_rd  = a0 ? {r_cnt, 2'b00, r_ovf, !w_empty}
                    : (w_empty ? 8'hFF : r_mem[r_rp]);
  assign d     = n_kb_oe ? 8'bz : w_rd;
  assign n_row = r_nrow;
  assign n_int = r_nint;
endmodule

// File: tb/tb_kb_scan_ctrl.sv
// Directed bench for kb_scan_ctrl: key matrix model, CPU read/write strobes,
// hand-computed event codes and status bytes.
module tb_kb_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst, a0, n_kb_oe, kb_cp;
  wire  [7:0]  d;
  logic [7:0]  tb_d;
  logic        tb_den;
  logic [7:0]  n_row, n_col;
  logic        n_int;
  logic [63:0] keys;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign d = tb_den ? tb_d : 8'bz;

  always_comb begin
    n_col = 8'hFF;
    for (int r = 0; r < 8; r++)
      if (!n_row[r]) n_col = n_col & ~keys[r*8 +: 8];
  end

  kb_scan_ctrl #(.SCAN_DIV(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .a0(a0), .n_kb_oe(n_kb_oe), .kb_cp(kb_cp),
    .d(d), .n_row(n_row), .n_col(n_col), .n_int(n_int)
  );

  task automatic rd(input logic sel, output logic [7:0] v);
    @(negedge clk);
    a0 = sel; n_kb_oe = 1'b0;
    @(posedge clk);
    @(negedge clk);
    v = d; n_kb_oe = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic wr(input logic sel, input logic [7:0] v);
    @(negedge clk);
    a0 = sel; tb_d = v; tb_den = 1'b1; kb_cp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    kb_cp = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_den = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_row(input logic [7:0] val, input string nm);
    int t;
    t = 0;
    while (n_row == val && t < 400) begin @(negedge clk); t++; end
    t = 0;
    while (n_row != val && t < 400) begin @(negedge clk); t++; end
    n_chk++;
    if (n_row !== val) begin
      n_fail++;
      $display("FAIL %s: n_row=%h required %h (timeout)", nm, n_row, val);
    end
  endtask

  task automatic wait_int_low(input string nm);
    int t;
    t = 0;
    while (n_int !== 1'b0 && t < 500) begin @(negedge clk); t++; end
    n_chk++;
    if (n_int !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: n_int=%b required 0 (timeout)", nm, n_int);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1; keys = '0; a0 = 1'b0; n_kb_oe = 1'b1; kb_cp = 1'b1;
    tb_den = 1'b0; tb_d = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (n_row !== 8'hFE) begin n_fail++; $display("FAIL reset_row: got %h required FE", n_row); end
    n_chk++;
    if (n_int !== 1'b1) begin n_fail++; $display("FAIL reset_int: got %b required 1", n_int); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); tb_d = 8'hA5; tb_den = 1'b1;
    #1;
    n_chk++;
    if (d !== 8'hA5) begin n_fail++; $display("FAIL reset_hiz: bus %h required A5", d); end
    tb_den = 1'b0;
    rd(1'b1, v);
    n_chk++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h required 00", v); end
  endtask

  task automatic test_press();
    logic [7:0] v;
    keys[21] = 1'b1;
    wait_int_low("press_int");
    repeat (2) @(posedge clk);
    rd(1'b1, v);
    n_chk++;
    if (v !== 8'h11) begin n_fail++; $display("FAIL press_status: got %h required 11", v); end
    rd(1'b0, v);
    n_chk++;
    if (v !== 8'h15) begin n_fail++; $display("FAIL press_code: got %h required 15", v); end
    @(negedge clk);
    n_chk++;
    if (n_int !== 1'b1) begin n_fail++; $display("FAIL press_int_clr: got %b required 1", n_int); end
    rd(1'b1, v);
    n_chk++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL press_status_after: got %h required 00", v); end
  endtask

  task automatic test_release();
    logic [7:0] v;
    keys[21] = 1'b0;
    wait_int_low("release_int");
    rd(1'b0, v);
    n_chk++;
    if (v !== 8'h95) begin n_fail++; $display("FAIL release_code: got %h required 95", v); end
  endtask

  task automatic test_glitch();
    logic [7:0] v;
    wait_row(8'hFE, "glitch_align");
    keys[0] = 1'b1;
    wait_row(8'hFD, "glitch_end");
    keys[0] = 1'b0;
    repeat (600) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (n_int !== 1'b1) begin n_fail++; $display("FAIL glitch_int: got %b required 1", n_int); end
    rd(1'b1, v);
    n_chk++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL glitch_status: got %h required 00", v); end
  endtask

  task automatic test_empty_read();
    logic [7:0] v;
    rd(1'b0, v);
    n_chk++;
    if (v !== 8'hFF) begin n_fail++; $display("FAIL empty_data: got %h required FF", v); end
    rd(1'b1, v);
    n_chk++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL empty_status: got %h required 00", v); end
  endtask

  task automatic test_serialise();
    logic [7:0] v, e;
    wait_row(8'hFE, "ser_align");
    keys[24 +: 16] = 16'hFFFF;
    wait_row(8'hDF, "ser_scan1");
    wait_row(8'hDF, "ser_scan2");
    rd(1'b1, v);
    n_chk++;
    if (v !== 8'h83) begin n_fail++; $display("FAIL ser_full_status: got %h required 83", v); end
    // pop lands on the same clock as the row-4 col-0 push of the next scan
    wait_row(8'hEF, "ser_row4");
    a0 = 1'b0; n_kb_oe = 1'b0;
    #1;
    n_chk++;
    if (d !== 8'h18) begin n_fail++; $display("FAIL ser_head: got %h required 18", d); end
    repeat (16) @(posedge clk);
    @(negedge clk);
    n_kb_oe = 1'b1;
    repeat (10) @(posedge clk);
    rd(1'b1, v);
    n_chk++;
    if (v !== 8'h83) begin n_fail++; $display("FAIL ser_pushpop_status: got %h required 83", v); end
    for (int i = 0; i < 8; i++) begin
      e = (i < 7) ? 8'(8'h19 + i) : 8'h20;
      rd(1'b0, v);
      n_chk++;
      if (v !== e) begin n_fail++; $display("FAIL ser_drain1[%0d]: got %h required %h", i, v, e); end
    end
    wait_row(8'hDF, "ser_scan4");
    for (int i = 0; i < 7; i++) begin
      e = 8'(8'h21 + i);
      rd(1'b0, v);
      n_chk++;
      if (v !== e) begin n_fail++; $display("FAIL ser_drain2[%0d]: got %h required %h", i, v, e); end
    end
    rd(1'b1, v);
    n_chk++;
    if (v !== 8'h02) begin n_fail++; $display("FAIL ser_ovf_status: got %h required 02", v); end
    wr(1'b1, 8'h02);
    rd(1'b1, v);
    n_chk++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL ser_ovf_clr: got %h required 00", v); end
    repeat (400) @(posedge clk);
    rd(1'b1, v);
    n_chk++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL ser_no_dup: got %h required 00", v); end
    keys = '0;
    do_reset();
  endtask

  task automatic test_status_cmd();
    logic [7:0] v;
    keys[48 +: 3] = 3'b111;
    wait_int_low("cmd_int");
    repeat (10) @(posedge clk);
    rd(1'b1, v);
    n_chk++;
    if (v !== 8'h31) begin n_fail++; $display("FAIL cmd_status3: got %h required 31", v); end
    rd(1'b1, v);
    n_chk++;
    if (v !== 8'h31) begin n_fail++; $display("FAIL cmd_status_nopop: got %h required 31", v); end
    wr(1'b0, 8'h03);
    rd(1'b1, v);
    n_chk++;
    if (v !== 8'h31) begin n_fail++; $display("FAIL cmd_a0_ignored: got %h required 31", v); end
    wr(1'b1, 8'h03);
    rd(1'b1, v);
    n_chk++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL cmd_flush: got %h required 00", v); end
    @(negedge clk);
    n_chk++;
    if (n_int !== 1'b1) begin n_fail++; $display("FAIL cmd_flush_int: got %b required 1", n_int); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v, e;
    wait_row(8'hBF, "rst_align");
    repeat (18) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if (n_row !== 8'hFE) begin n_fail++; $display("FAIL rstmid_row: got %h required FE", n_row); end
    n_chk++;
    if (n_int !== 1'b1) begin n_fail++; $display("FAIL rstmid_int: got %b required 1", n_int); end
    tb_d = 8'h5A; tb_den = 1'b1;
    #1;
    n_chk++;
    if (d !== 8'h5A) begin n_fail++; $display("FAIL rstmid_hiz: bus %h required 5A", d); end
    tb_den = 1'b0;
    @(negedge clk); rst = 1'b0;
    rd(1'b1, v);
    n_chk++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL rstmid_status: got %h required 00", v); end
    wait_int_low("rstmid_rereport");
    repeat (10) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      e = 8'(8'h30 + i);
      rd(1'b0, v);
      n_chk++;
      if (v !== e) begin n_fail++; $display("FAIL rstmid_code[%0d]: got %h required %h", i, v, e); end
    end
    rd(1'b1, v);
    n_chk++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL rstmid_final: got %h required 00", v); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_glitch();
    test_empty_read();
    test_serialise();
    test_status_cmd();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
